// File: rtl/uni_shiftreg_pkg.sv
// uni_shiftreg_pkg: shared encodings, FSM states and default width for the shift-register block.
package uni_shiftreg_pkg;
  localparam int DEF_WIDTH = 4;
  localparam logic [1:0] SEL_CLR  = 2'b00;
  localparam logic [1:0] SEL_SHL  = 2'b01;
  localparam logic [1:0] SEL_SHR  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;
endpackage

// File: rtl/uni_shiftreg_ctrl_if.sv
// uni_shiftreg_ctrl_if: command/response handshake between a requester and the controller.
interface uni_shiftreg_ctrl_if
  import uni_shiftreg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_cnt;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  modport master(output cmd_valid, cmd_op, cmd_data, cmd_cnt, input cmd_ready, rsp_valid, rsp_data);
  modport slave(input cmd_valid, cmd_op, cmd_data, cmd_cnt, output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/uni_shiftreg.sv
// uni_shiftreg: universal shift register (clear / shift left / shift right / hold).
module uni_shiftreg
  import uni_shiftreg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_sel,
  input  logic             i_in,
  output logic [WIDTH-1:0] o_q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) o_q <= '0;
    else o_q <= i_sel == SEL_CLR ? '0 :
                i_sel == SEL_SHL ? {o_q[WIDTH-2:0], i_in} :
                i_sel == SEL_SHR ? {i_in, o_q[WIDTH-1:1]} : o_q;
endmodule

// File: rtl/uni_shiftreg_ctrl.sv
// uni_shiftreg_ctrl: sequences one command at a time onto a uni_shiftreg and reports its contents.
module uni_shiftreg_ctrl
  import uni_shiftreg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  uni_shiftreg_ctrl_if.slave   ctl,
  output logic [1:0]           sr_sel,
  output logic                 sr_in,
  input  logic [WIDTH-1:0]     sr_q,
  output logic                 busy
);
  state_t           r_state, w_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt, w_n;
  logic             w_acc;
  assign w_acc = ctl.cmd_valid && ctl.cmd_ready;
  assign w_n = ctl.cmd_op == SEL_CLR ? CNT_W'(1) :
               ctl.cmd_op == SEL_SHL ? CNT_W'(WIDTH) :
               ctl.cmd_cnt > CNT_W'(WIDTH) ? CNT_W'(WIDTH) : ctl.cmd_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == S_IDLE ? (w_acc ? (w_n == '0 ? S_RESP : S_RUN) : S_IDLE) :
             r_state == S_RUN  ? (r_cnt == CNT_W'(1) ? S_RESP : S_RUN) : S_IDLE;
  // LOAD data shifts out MSB first, so the top bit is always the next serial bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_op   <= SEL_HOLD;
      r_data <= '0;
      r_cnt  <= '0;
    end else if (w_acc) begin
      r_op   <= ctl.cmd_op;
      r_data <= ctl.cmd_data;
      r_cnt  <= w_n;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_op == SEL_SHL) r_data <= {r_data[WIDTH-2:0], 1'b0};
    end
  always_comb begin
    ctl.cmd_ready = r_state == S_IDLE;
    ctl.rsp_valid = r_state == S_RESP;
    ctl.rsp_data  = r_state == S_RESP ? sr_q : '0;
    busy          = r_state != S_IDLE;
    sr_sel        = r_state == S_RUN ? r_op : SEL_HOLD;
    sr_in         = r_state == S_RUN && ((r_op == SEL_SHL && r_data[WIDTH-1]) || (r_op == SEL_SHR && r_data[0]));
  end
endmodule

// File: tb/tb_uni_shiftreg_ctrl.sv
// tb_uni_shiftreg_ctrl: directed self-checking bench for the controller driving a uni_shiftreg.
module tb_uni_shiftreg_ctrl;
  import uni_shiftreg_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sr_sel;
  logic       sr_in, busy;
  logic [3:0] sr_q;
  int         n_chk = 0, n_err = 0, acc = 0, a0;
  uni_shiftreg_ctrl_if #(.WIDTH(4), .CNT_W(3)) bus();
  uni_shiftreg_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .ctl(bus.slave), .sr_sel(sr_sel), .sr_in(sr_in), .sr_q(sr_q), .busy(busy)
  );
  uni_shiftreg #(.WIDTH(4)) u_sr (.clk(clk), .rst(rst), .i_sel(sr_sel), .i_in(sr_in), .o_q(sr_q));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.cmd_valid && bus.cmd_ready) acc <= acc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] op, input logic [3:0] d, input logic [2:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_data = d;
    bus.cmd_cnt = c;
    chk("ready_before_accept", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  // expects n RUN cycles with sel, serial bits ins[3] first, then RESP carrying d, then IDLE
  task automatic run(input logic [1:0] sel, input int n, input logic [3:0] ins, input logic [3:0] d);
    for (int i = 0; i < n; i++) begin
      chk("run_sel", sr_sel, sel);
      chk("run_in", sr_in, ins[3-i]);
      chk("run_busy", busy, 1);
      chk("run_ready", bus.cmd_ready, 0);
      chk("run_rsp", bus.rsp_valid, 0);
      tick();
    end
    chk("resp_valid", bus.rsp_valid, 1);
    chk("resp_data", bus.rsp_data, d);
    chk("resp_sel", sr_sel, SEL_HOLD);
    chk("resp_in", sr_in, 0);
    chk("resp_ready", bus.cmd_ready, 0);
    tick();
    chk("idle_valid", bus.rsp_valid, 0);
    chk("idle_data", bus.rsp_data, 0);
    chk("idle_busy", busy, 0);
    chk("idle_sel", sr_sel, SEL_HOLD);
    chk("idle_ready", bus.cmd_ready, 1);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_data = 4'h0;
    bus.cmd_cnt = 3'd0;
    tick();
    tick();
    chk("rst_sel", sr_sel, 2'b11);
    chk("rst_in", sr_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    rst = 1'b0;
    tick();
    chk("rst_ready", bus.cmd_ready, 1);
    send(2'b01, 4'b1011, 3'd0);
    run(2'b01, 4, 4'b1011, 4'b1011);
    send(2'b10, 4'b0001, 3'd2);
    run(2'b10, 2, 4'b1111, 4'b1110);
    send(2'b01, 4'b0110, 3'd0);
    run(2'b01, 4, 4'b0110, 4'b0110);
    send(2'b11, 4'b1111, 3'd3);
    run(2'b11, 3, 4'b0000, 4'b0110);
    send(2'b00, 4'b1111, 3'd5);
    run(2'b00, 1, 4'b0000, 4'b0000);
    send(2'b10, 4'b0001, 3'd0);
    run(2'b10, 0, 4'b0000, 4'b0000);
    send(2'b10, 4'b0001, 3'd7);
    run(2'b10, 4, 4'b1111, 4'b1111);
    a0 = acc;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'b01;
    bus.cmd_data = 4'b1100;
    tick();
    run(2'b01, 4, 4'b1100, 4'b1100);
    tick();
    bus.cmd_valid = 1'b0;
    run(2'b01, 4, 4'b1100, 4'b1100);
    chk("held_valid_accepts", acc - a0, 2);
    send(2'b01, 4'b1010, 3'd0);
    chk("pre_rst_sel1", sr_sel, 2'b01);
    tick();
    chk("pre_rst_sel2", sr_sel, 2'b01);
    rst = 1'b1;
    #1;
    chk("mid_rst_sel", sr_sel, 2'b11);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in", sr_in, 0);
    chk("mid_rst_rsp", bus.rsp_valid, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_no_rsp", bus.rsp_valid, 0);
      chk("post_rst_idle", busy, 0);
      tick();
    end
    send(2'b01, 4'b0101, 3'd0);
    run(2'b01, 4, 4'b0101, 4'b0101);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uni_shiftreg_ctrl.md
UNI_SHIFTREG_CTRL -- requirements
Module: uni_shiftreg_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the attached uni_shiftreg and of the data paths.
REQ-002 Parameter: CNT_W, default 3, width of cmd_cnt; it SHALL be wide enough to hold WIDTH.
REQ-003 Port: clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port: rst, input, 1, reset; asynchronous, active-high.
REQ-005 Port: cmd_valid, input, 1, a command is presented.
REQ-006 Port: cmd_ready, output, 1, the controller accepts a command this cycle.
REQ-007 Port: cmd_op, input, 2, operation: 00 CLEAR, 01 LOAD, 10 SHR, 11 HOLD.
REQ-008 Port: cmd_data, input, WIDTH, LOAD word; bit 0 is the SHR fill bit.
REQ-009 Port: cmd_cnt, input, CNT_W, number of active cycles for SHR and HOLD.
REQ-010 Port: sr_sel, output, 2, drives the shift-register sel: 00 clear, 01 shift left, 10 shift right, 11 hold.
REQ-011 Port: sr_in, output, 1, drives the shift-register serial input.
REQ-012 Port: sr_q, input, WIDTH, shift-register parallel output.
REQ-013 Port: rsp_valid, output, 1, one-cycle completion pulse.
REQ-014 Port: rsp_data, output, WIDTH, shift-register contents at completion.
REQ-015 Port: busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 Shift-register contract: left is q<={q[WIDTH-2:0],in}; right is q<={in,q[WIDTH-1:1]}; both on the clk edge.
REQ-017 FSM states: IDLE, RUN, RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
REQ-019 On accept, the FSM SHALL latch op, data and an active-cycle count N, then enter RUN (or RESP if N=0).
REQ-020 N values: CLEAR N=1; LOAD N=WIDTH; SHR/HOLD N=min(cmd_cnt,WIDTH).
REQ-021 cmd_cnt=0 for SHR/HOLD SHALL give N=0, so RESP follows the accept directly.
REQ-022 RUN SHALL last exactly N cycles, with sr_sel equal to the latched op each cycle.
REQ-023 sr_in during LOAD SHALL be cmd_data[WIDTH-1] in the first RUN cycle down to bit 0 in the last (MSB first).
REQ-024 sr_in during SHR SHALL be the latched fill bit; during CLEAR, HOLD, IDLE and RESP it SHALL be 0.
REQ-025 In IDLE and RESP, sr_sel SHALL be 11 (hold).
REQ-026 RESP SHALL last one cycle: rsp_valid=1 and rsp_data=sr_q, then IDLE.
REQ-027 Total latency from the accept edge to rsp_valid SHALL be N+1 cycles; the next accept is possible on the edge ending RESP+1 (IDLE).
REQ-028 sr_sel, sr_in, rsp_valid and busy SHALL be decoded from registered state only, with no combinational path from cmd_* to sr_*.
REQ-029 rsp_data SHALL be 0 whenever rsp_valid=0.
REQ-030 Commands presented while busy SHALL be ignored and not queued; cmd_valid in RESP is not accepted.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, sr_sel=11, sr_in=0, rsp_valid=0, rsp_data=0, busy=0 and cmd_ready=1 (after release), and clear the counter and latches.
REQ-032 Reset mid-RUN SHALL abort the operation without emitting rsp_valid; the first command after release is handled normally.

Structure
REQ-033 Package uni_shiftreg_pkg SHALL hold: the op/sel encodings (SEL_CLR, SEL_SHL, SEL_SHR, SEL_HOLD), the FSM state enum, and the default WIDTH.
REQ-034 The controller SHALL be a single module with no sub-modules; the bench instantiates uni_shiftreg beside it.

Verification
REQ-035 LOAD, data=1011 -> sr_sel=01 for 4 cycles; sr_in=1,0,1,1; rsp_valid 5 cycles after accept; rsp_data=1011.
REQ-036 After LOAD 1011, SHR cnt=2 fill=1 -> sr_sel=10 for 2 cycles; rsp_data=1110.
REQ-037 HOLD cnt=3 after LOAD 0110 -> sr_sel=11 for 3 cycles; rsp_data=0110; then CLEAR -> rsp_data=0000 after 2 cycles.
REQ-038 SHR cnt=0 -> rsp_valid on the cycle after accept, sr_sel never 10; SHR cnt=7 -> saturates to exactly 4 shift cycles.
REQ-039 cmd_valid held high throughout LOAD -> cmd_ready=0 while busy; exactly one accept per IDLE cycle, none in RUN or RESP.
REQ-040 rst asserted in the 2nd RUN cycle of LOAD -> sr_sel=11 and busy=0 within the same cycle; no rsp_valid; next LOAD 0101 -> rsp_data=0101.
